// File: rtl/glip_egress_arb_pkg.sv
// Purpose : shared types, header layout and header builder for the GLIP egress channel arbiter.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Contents: arb_state_e FSM encoding, header field widths/positions, build_hdr().
package glip_egress_arb_pkg;

  // Header word layout: {channel id, burst length}.
  localparam int HDR_CH_W    = 4;
  localparam int HDR_LEN_W   = 12;
  localparam int HDR_W       = HDR_CH_W + HDR_LEN_W;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_CH_LSB  = HDR_LEN_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } arb_state_e;

  function automatic logic [HDR_W-1:0] build_hdr(input logic [HDR_CH_W-1:0]  ch,
                                                  input logic [HDR_LEN_W-1:0] len);
    logic [HDR_W-1:0] w;
    w = '0;
    w[HDR_CH_LSB  +: HDR_CH_W]  = ch;
    w[HDR_LEN_LSB +: HDR_LEN_W] = len;
    return w;
  endfunction

endpackage

// File: rtl/glip_egress_channel_arbiter_if.sv
// Purpose : bundles the per-channel source buses and the egress FIFO-side bus.
// Latency : n/a (wires only).
// Backpres: valid/ready on both sides; the arbiter uses the master modport.
// Signals : ch_valid/ch_ready/ch_data/ch_avail (sources), out_valid/out_ready/out_data (egress FIFO).
interface glip_egress_channel_arbiter_if
  import glip_egress_arb_pkg::*;
#(
  parameter int WIDTH  = HDR_W,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12
);
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH-1:0]       ch_ready;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [NUM_CH*CNT_W-1:0] ch_avail;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;

  // master: the arbiter itself
  modport master (
    input  ch_valid, ch_data, ch_avail, out_ready,
    output ch_ready, out_valid, out_data
  );

  // slave: the sources plus the egress FIFO around the arbiter
  modport slave (
    output ch_valid, ch_data, ch_avail, out_ready,
    input  ch_ready, out_valid, out_data
  );
endinterface

// File: rtl/glip_rr_arbiter.sv
// Purpose : combinational round-robin search over req, starting one past ptr.
// Latency : 0 cycles (purely combinational).
// Backpres: none; the caller decides when to take the grant.
// Ports   : req[N], ptr -> gnt_valid, gnt_idx.
module glip_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] cand;

  // Offsets 1..N visit every channel once, ptr itself last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/glip_egress_channel_arbiter.sv
// Purpose : shares the GLIP egress FIFO between NUM_CH sources; each grant sends a header then len words.
// Latency : grant decided in IDLE, header visible the next cycle; data words pass combinationally.
// Backpres: header held until out_ready; data ch_ready follows out_ready, out_valid follows the source.
// Ports   : clk, int_rst (async, active-high), enable, bus (master modport), busy, grant_id.
module glip_egress_channel_arbiter
  import glip_egress_arb_pkg::*;
#(
  parameter int WIDTH     = HDR_W,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = HDR_CH_W,
  parameter int LEN_W     = HDR_LEN_W,
  parameter int MAX_BURST = 256,
  parameter int CNT_W     = 12
) (
  input  logic                           clk,
  input  logic                           int_rst,
  input  logic                           enable,
  glip_egress_channel_arbiter_if.master  bus,
  output logic                           busy,
  output logic [CH_W-1:0]                grant_id
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [LEN_W-1:0]  rem_q,   rem_d;
  logic [PTR_W-1:0]  ptr_q,   ptr_d;

  logic [CNT_W-1:0]  avail_arr [NUM_CH];
  logic [WIDTH-1:0]  data_arr  [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic              gnt_valid;
  logic [PTR_W-1:0]  gnt_idx;
  logic [CNT_W-1:0]  avail_sel;
  logic [LEN_W-1:0]  len_clip;
  logic              xfer;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      avail_arr[i] = bus.ch_avail[i*CNT_W +: CNT_W];
      data_arr[i]  = bus.ch_data[i*WIDTH +: WIDTH];
      req[i]       = (avail_arr[i] != '0);
    end
  end

  glip_rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (PTR_W)
  ) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Long requests are cut to MAX_BURST; the source keeps advertising the rest.
  always_comb begin
    avail_sel = avail_arr[gnt_idx];
    if (int'(avail_sel) > MAX_BURST) len_clip = LEN_W'(MAX_BURST);
    else                             len_clip = LEN_W'(avail_sel);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    len_d         = len_q;
    rem_d         = rem_q;
    ptr_d         = ptr_q;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.ch_ready  = '0;
    busy          = 1'b0;
    xfer          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && gnt_valid) begin
          grant_d = CH_W'(gnt_idx);
          len_d   = len_clip;
          ptr_d   = gnt_idx;
          state_d = HEADER;
        end
      end

      HEADER: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = build_hdr(grant_q, len_q);
        if (bus.out_ready) begin
          rem_d   = len_q;
          state_d = DATA;
        end
      end

      DATA: begin
        // ptr_q equals the granted channel for the whole burst.
        busy                = 1'b1;
        bus.out_valid       = bus.ch_valid[ptr_q];
        bus.out_data        = data_arr[ptr_q];
        bus.ch_ready[ptr_q] = bus.out_ready;
        xfer                = bus.ch_valid[ptr_q] && bus.out_ready;
        if (xfer) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge int_rst) begin
    if (int_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      ptr_q   <= PTR_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_id = grant_q;

endmodule
